// File: rtl/imem_decomp.sv
// ---------------------------------------------------------------------------
// imem_decomp -- compressed instruction memory, refill-side responder
//
// Every 32-bit instruction word of the image is stored as a 16-bit code:
//   code[15] = 1 : word = dict_mem[code[7:0]]  (code[14:8] must be 0, else 0)
//   code[15] = 0 : word = raw_mem[code[14:0]]
// Addresses beyond the image and dictionary/raw indices beyond the array
// depths decode to 0. The reconstructed word is returned with a one-cycle
// mem_ready strobe, 2 + EXTRA_LATENCY edges after the request is accepted.
//
// The three storage arrays (code_mem, dict_mem, raw_mem) have no write port;
// they are preloaded from outside (hierarchically) before use.
//
// Optional build feature (macro IMEM_DECOMP_STATS_EN): adds saturating
// response counters dict_hits / raw_hits.
//
// Ports:
//   clk           in   1   clock
//   reset         in   1   synchronous, active-high reset
//   mem_valid     in   1   request, held with stable mem_addr until ready
//   mem_ready     out  1   one-cycle response strobe
//   mem_addr      in   32  byte address, bits [1:0] ignored
//   mem_rdata     out  32  decoded word, held until the next response
//   dbg_mem_valid out  1   one-cycle pulse per accepted request
//   dict_hits     out  32  (IMEM_DECOMP_STATS_EN) responses via dictionary
//   raw_hits      out  32  (IMEM_DECOMP_STATS_EN) responses via raw / zero
// ---------------------------------------------------------------------------
module imem_decomp #(
    parameter int unsigned NUM_WORDS     = 262144,
    parameter int unsigned DICT_DEPTH    = 256,
    parameter int unsigned RAW_DEPTH     = 32768,
    parameter int unsigned EXTRA_LATENCY = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    output logic [31:0] mem_rdata,
    output logic        dbg_mem_valid
`ifdef IMEM_DECOMP_STATS_EN
    ,
    output logic [31:0] dict_hits,
    output logic [31:0] raw_hits
`endif
);

    localparam int unsigned IDX_W   = (NUM_WORDS  > 1) ? $clog2(NUM_WORDS)  : 1;
    localparam int unsigned DICT_AW = (DICT_DEPTH > 1) ? $clog2(DICT_DEPTH) : 1;
    localparam int unsigned RAW_AW  = (RAW_DEPTH  > 1) ? $clog2(RAW_DEPTH)  : 1;

    // Byte-address limit of the image; 34 bits so 4*NUM_WORDS cannot wrap.
    localparam logic [33:0] ADDR_LIMIT = 34'(NUM_WORDS) << 2;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        FETCH,
        WAIT
    } state_e;

    // NOTE: storage arrays are deliberately left out of reset; clearing a
    // memory needs a write sweep, and the contents are preloaded anyway.
    logic [15:0] code_mem [NUM_WORDS];
    logic [31:0] dict_mem [DICT_DEPTH];
    logic [31:0] raw_mem  [RAW_DEPTH];

    state_e             state_q;
    logic [7:0]         cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic               oor_q;      // request address was beyond the image
    logic [15:0]        code_q;
    logic [31:0]        hold_q;     // decoded word parked while waiting
    logic               ready_q;
    logic [31:0]        rdata_q;
    logic               dbg_q;

    logic               addr_oor;
    logic [31:0]        word_d;
    logic               dict_path_d;
    logic               resp_fire;
    logic [7:0]         dict_idx;
    logic [14:0]        raw_idx;

    assign addr_oor = ({2'b00, mem_addr} >= ADDR_LIMIT);
    assign dict_idx = code_q[7:0];
    assign raw_idx  = code_q[14:0];

    // Decode of the registered code into the final instruction word.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        word_d      = '0;
        dict_path_d = 1'b0;
        if (!oor_q) begin
            if (code_q[15]) begin
                dict_path_d = 1'b1;
                if ((code_q[14:8] == 7'd0) && (32'(dict_idx) < DICT_DEPTH)) begin
                    word_d = dict_mem[DICT_AW'(dict_idx)];
                end
            end else if (32'(raw_idx) < RAW_DEPTH) begin
                word_d = raw_mem[RAW_AW'(raw_idx)];
            end
        end
    end

    // A response is issued directly from FETCH when there is no extra
    // latency, otherwise from WAIT once the counter has run down to 1.
    always_comb begin
        resp_fire = 1'b0;
        if (state_q == FETCH) begin
            resp_fire = (EXTRA_LATENCY == 0);
        end else if (state_q == WAIT) begin
            resp_fire = (cnt_q <= 8'd1);
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            oor_q   <= 1'b0;
            code_q  <= '0;
            hold_q  <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            dbg_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            dbg_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    // While ready is high the initiator is dropping valid,
                    // so that cycle never starts a new transaction.
                    if (mem_valid && !ready_q) begin
                        idx_q   <= mem_addr[IDX_W+1:2];
                        oor_q   <= addr_oor;
                        dbg_q   <= 1'b1;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    code_q  <= code_mem[idx_q];
                    state_q <= FETCH;
                end
                FETCH: begin
                    hold_q <= word_d;
                    if (resp_fire) begin
                        rdata_q <= word_d;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q   <= 8'(EXTRA_LATENCY);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (resp_fire) begin
                        rdata_q <= hold_q;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_ready     = ready_q;
    assign mem_rdata     = rdata_q;
    assign dbg_mem_valid = dbg_q;

`ifdef IMEM_DECOMP_STATS_EN
    logic        hold_dict_q;   // path of the word parked in hold_q
    logic        resp_dict;
    logic [31:0] dict_hits_q;
    logic [31:0] raw_hits_q;

    assign resp_dict = (state_q == FETCH) ? dict_path_d : hold_dict_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_dict_q <= 1'b0;
            dict_hits_q <= '0;
            raw_hits_q  <= '0;
        end else begin
            if (state_q == FETCH) begin
                hold_dict_q <= dict_path_d;
            end
            if (resp_fire) begin
                if (resp_dict) begin
                    if (dict_hits_q != 32'hFFFF_FFFF) dict_hits_q <= dict_hits_q + 32'd1;
                end else begin
                    if (raw_hits_q != 32'hFFFF_FFFF) raw_hits_q <= raw_hits_q + 32'd1;
                end
            end
        end
    end

    assign dict_hits = dict_hits_q;
    assign raw_hits  = raw_hits_q;
`endif

endmodule

// File: tb/tb_imem_decomp.sv
// ---------------------------------------------------------------------------
// tb_imem_decomp -- self-checking bench for imem_decomp
//
// Two instances share the clock and reset: u_dut0 (EXTRA_LATENCY=0) and
// u_dut5 (EXTRA_LATENCY=5). Both get identical memory images, written
// hierarchically, and a reference model computes every expected word from
// the decode rules using associative arrays and plain arithmetic.
// ---------------------------------------------------------------------------
module tb_imem_decomp;

    localparam int unsigned NUM_WORDS  = 262144;
    localparam int unsigned DICT_DEPTH = 256;
    localparam int unsigned RAW_DEPTH  = 32768;

    logic        clk = 1'b0;
    logic        reset;
    logic        vld  [2];
    logic [31:0] adr  [2];
    logic        rdy  [2];
    logic [31:0] rdat [2];
    logic        dbg  [2];
`ifdef IMEM_DECOMP_STATS_EN
    logic [31:0] dh [2];
    logic [31:0] rh [2];
`endif

    int total = 0;
    int bad   = 0;

    // Reference image.
    logic [15:0] m_code [int];
    logic [31:0] m_dict [int];
    logic [31:0] m_raw  [int];

    always #5 clk = ~clk;

    imem_decomp #(.NUM_WORDS(NUM_WORDS), .DICT_DEPTH(DICT_DEPTH),
                  .RAW_DEPTH(RAW_DEPTH), .EXTRA_LATENCY(0)) u_dut0 (
        .clk(clk), .reset(reset), .mem_valid(vld[0]), .mem_ready(rdy[0]),
        .mem_addr(adr[0]), .mem_rdata(rdat[0]), .dbg_mem_valid(dbg[0])
`ifdef IMEM_DECOMP_STATS_EN
        , .dict_hits(dh[0]), .raw_hits(rh[0])
`endif
    );

    imem_decomp #(.NUM_WORDS(NUM_WORDS), .DICT_DEPTH(DICT_DEPTH),
                  .RAW_DEPTH(RAW_DEPTH), .EXTRA_LATENCY(5)) u_dut5 (
        .clk(clk), .reset(reset), .mem_valid(vld[1]), .mem_ready(rdy[1]),
        .mem_addr(adr[1]), .mem_rdata(rdat[1]), .dbg_mem_valid(dbg[1])
`ifdef IMEM_DECOMP_STATS_EN
        , .dict_hits(dh[1]), .raw_hits(rh[1])
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic put_code(input int i, input logic [15:0] v);
        m_code[i] = v;
        u_dut0.code_mem[18'(i)] = v;
        u_dut5.code_mem[18'(i)] = v;
    endtask

    task automatic put_dict(input int i, input logic [31:0] v);
        m_dict[i] = v;
        u_dut0.dict_mem[8'(i)] = v;
        u_dut5.dict_mem[8'(i)] = v;
    endtask

    task automatic put_raw(input int i, input logic [31:0] v);
        m_raw[i] = v;
        u_dut0.raw_mem[15'(i)] = v;
        u_dut5.raw_mem[15'(i)] = v;
    endtask

    // Expected instruction word for a byte address, straight from the rules.
    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int unsigned code;
        if (longint'(a) >= 4 * longint'(NUM_WORDS)) return 32'h0;
        if (!m_code.exists(int'(a / 4))) return 32'h0;
        code = int'(m_code[int'(a / 4)]);
        if (code >= 32768) begin
            if (((code >> 8) & 127) != 0) return 32'h0;
            if ((code & 255) >= DICT_DEPTH) return 32'h0;
            return m_dict[int'(code & 255)];
        end
        if (code >= RAW_DEPTH) return 32'h0;
        return m_raw[int'(code)];
    endfunction

    // One request on instance s. Returns edges from acceptance to ready,
    // the returned word and the number of dbg pulses seen. Also checks
    // the ready pulse width and that rdata holds afterwards.
    task automatic req(input int s, input logic [31:0] a, input bit scramble,
                       output int lat, output logic [31:0] data, output int dbgs);
        @(negedge clk);
        vld[s] = 1'b1;
        adr[s] = a;
        lat    = -1;
        data   = 32'hxxxx_xxxx;
        dbgs   = 0;
        @(posedge clk); #1;
        check("dbg_at_accept", 32'(dbg[s]), 32'd1);
        if (dbg[s]) dbgs++;
        if (scramble) adr[s] = $urandom;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            if (dbg[s]) dbgs++;
            if (rdy[s]) begin
                lat    = k;
                data   = rdat[s];
                vld[s] = 1'b0;
                break;
            end
        end
        vld[s] = 1'b0;
        @(posedge clk); #1;
        if (dbg[s]) dbgs++;
        check("ready_one_cycle", 32'(rdy[s]), 32'd0);
        check("rdata_hold", rdat[s], data);
    endtask

    task automatic txn(input string tag, input int s, input logic [31:0] a, input bit scramble);
        int          lat;
        logic [31:0] data;
        int          dbgs;
        req(s, a, scramble, lat, data, dbgs);
        check({tag, "_latency"}, 32'(lat), (s == 0) ? 32'd2 : 32'd7);
        check({tag, "_rdata"}, data, ref_word(a));
        check({tag, "_dbg_count"}, 32'(dbgs), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=time-limit expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          rdy_e [$];
        int          dbg_e [$];
        logic [31:0] dq    [$];
        int          pulses;

        reset  = 1'b1;
        vld[0] = 1'b0; vld[1] = 1'b0;
        adr[0] = '0;   adr[1] = '0;

        // Directed image.
        put_code(0, 16'h8001);        put_dict(1, 32'hA5A5_0001);
        put_code(1, 16'h0002);        put_raw(2, 32'h1234_5678);
        put_code(4, 16'h8003);        put_dict(3, 32'h0000_0013);
        put_code(5, 16'h0007);        put_raw(7, 32'hDEAD_BEEF);
        put_code(6, 16'h8100);        put_dict(0, 32'h1111_2222);
        put_code(7, 16'h7FFF);        put_raw(32767, 32'hCAFE_F00D);
        put_code(NUM_WORDS - 1, 16'h8002); put_dict(2, 32'h0BAD_F00D);

        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check("reset_ready", 32'(rdy[s]), 32'd0);
            check("reset_rdata", rdat[s], 32'd0);
            check("reset_dbg", 32'(dbg[s]), 32'd0);
        end
        reset = 1'b0;

        // Dictionary and raw paths, zero extra latency.
        txn("dict_hit", 0, 32'h0000_0010, 1'b0);
        txn("raw_path", 0, 32'h0000_0017, 1'b0);

        // Extra latency of 5; the first response of this instance is raw.
        txn("lat5_raw", 1, 32'h0000_0014, 1'b1);
`ifdef IMEM_DECOMP_STATS_EN
        check("stats_raw_hits", rh[1], 32'd1);
        check("stats_dict_hits", dh[1], 32'd0);
`endif
        txn("lat5_dict", 1, 32'h0000_0010, 1'b0);

        // Boundaries.
        txn("addr_oor", 0, 32'h0010_0000, 1'b0);
        txn("dict_bad_bits", 0, 32'h0000_0018, 1'b0);
        txn("raw_top", 0, 32'h0000_001C, 1'b0);
        txn("last_word", 0, 32'h000F_FFFC, 1'b0);

        // Back-to-back with valid held high; address switched at ready.
        @(negedge clk);
        vld[0] = 1'b1;
        adr[0] = 32'h0000_0000;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (dbg[0]) dbg_e.push_back(k);
            if (rdy[0]) begin
                rdy_e.push_back(k);
                dq.push_back(rdat[0]);
                if (rdy_e.size() == 1) adr[0] = 32'h0000_0004;
                else vld[0] = 1'b0;
            end
        end
        vld[0] = 1'b0;
        check("b2b_ready_count", 32'(rdy_e.size()), 32'd2);
        check("b2b_dbg_count", 32'(dbg_e.size()), 32'd2);
        check("b2b_ready0_edge", (rdy_e.size() > 0) ? 32'(rdy_e[0]) : 32'hFFFF_FFFF, 32'd2);
        check("b2b_ready1_edge", (rdy_e.size() > 1) ? 32'(rdy_e[1]) : 32'hFFFF_FFFF, 32'd6);
        check("b2b_accept1_edge", (dbg_e.size() > 1) ? 32'(dbg_e[1]) : 32'hFFFF_FFFF, 32'd4);
        check("b2b_word0", (dq.size() > 0) ? dq[0] : 32'hxxxx_xxxx, ref_word(32'h0));
        check("b2b_word1", (dq.size() > 1) ? dq[1] : 32'hxxxx_xxxx, ref_word(32'h4));

        // Reset while the request sits in FETCH: no response, rdata cleared.
        @(negedge clk);
        vld[0] = 1'b1;
        adr[0] = 32'h0000_0014;
        @(posedge clk); #1;           // accepted, now in LOOKUP
        @(posedge clk); #1;           // now in FETCH
        reset  = 1'b1;
        vld[0] = 1'b0;
        @(posedge clk); #1;
        check("rst_fetch_ready", 32'(rdy[0]), 32'd0);
        check("rst_fetch_rdata", rdat[0], 32'd0);
        reset  = 1'b0;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (rdy[0]) pulses++;
        end
        check("rst_fetch_no_resp", 32'(pulses), 32'd0);
        check("rst_fetch_rdata_kept0", rdat[0], 32'd0);
        txn("after_reset", 0, 32'h0000_0010, 1'b0);

        // Randomized image region and requests on both instances.
        for (int j = 0; j < 24; j++) begin
            int          idx;
            int unsigned kind;
            logic [15:0] code;
            logic [31:0] a;
            idx  = 1000 + j * 17 + $urandom_range(0, 16);
            kind = $urandom_range(0, 4);
            case (kind)
                0, 1: begin
                    int d;
                    d = $urandom_range(0, 255);
                    put_dict(d, $urandom);
                    code = 16'h8000 | 16'(d);
                end
                2: begin
                    int r;
                    r = $urandom_range(0, 32767);
                    put_raw(r, $urandom);
                    code = 16'(r);
                end
                default: begin
                    code = 16'h8000 | 16'($urandom_range(1, 127) << 8) | 16'($urandom_range(0, 255));
                end
            endcase
            put_code(idx, code);
            a = (32'(idx) << 2) | 32'($urandom_range(0, 3));
            if (kind == 4 && $urandom_range(0, 1) == 1) a = 32'h0010_0000 + ($urandom % 32'h7FF0_0000);
            txn("random", j % 2, a, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
